// File: rtl/wb_arbiter_if.sv
// Register-file write-port bundle: an ALU result source, a buffered load-result
// source, and the arbitrated write port plus buffer status.
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  logic                  wena;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  logic [CNT_W-1:0]      fifo_count;
  logic                  stall_req;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  wena, waddr, wdata,
    input  fifo_count, stall_req
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output wena, waddr, wdata,
    output fifo_count, stall_req
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results own the register-file port; load results queue
// in a small FIFO and drain on idle cycles, killed if a younger ALU write hits them.
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] ent_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;

  logic                  alu_write;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  head_live;

  logic                  wena_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Register 0 is hardwired, so zero-address traffic is handshaken but dropped.
  always_comb begin
    alu_write = bus.alu_valid && (bus.alu_addr != '0);
    full      = (count == CNT_W'(FIFO_DEPTH));
    empty     = (count == '0);
    push      = bus.mem_valid && !full && (bus.mem_addr != '0);
    pop       = !alu_write && !empty;
    head_live = ent_valid[head];
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // The push is applied after the kill sweep so a same-cycle load to the ALU's
  // destination survives: it is younger than the ALU result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (alu_write) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (ent_addr[i] == bus.alu_addr) begin
            ent_valid[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        ent_addr[tail]  <= bus.mem_addr;
        ent_data[tail]  <= bus.mem_data;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // A killed head still pops but leaves the port idle, holding address and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wena_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (alu_write) begin
      wena_q  <= 1'b1;
      waddr_q <= bus.alu_addr;
      wdata_q <= bus.alu_data;
    end else if (pop && head_live) begin
      wena_q  <= 1'b1;
      waddr_q <= ent_addr[head];
      wdata_q <= ent_data[head];
    end else begin
      wena_q  <= 1'b0;
    end
  end

  assign bus.mem_ready  = !full;
  assign bus.stall_req  = full;
  assign bus.fifo_count = count;
  assign bus.wena       = wena_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: stimulus queues expected writes with
// their cycle, and a negedge monitor matches every write-port event against them.
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expq [$];
  exp_t mon_e;

  wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) bus ();

  wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic apply_stimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expect_write(input int c, input logic [4:0] a, input logic [31:0] d);
    expq.push_back('{c, a, d});
  endtask

  // Every write must match the oldest expectation, and an expectation whose cycle
  // has passed without a write is reported as missing.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wena) begin
        if (expq.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_write: got r%0d=0x%0h, expected no write (cycle %0d)",
                   bus.waddr, bus.wdata, cyc);
        end else begin
          mon_e = expq.pop_front();
          check_output("write_cycle", 32'(cyc), 32'(mon_e.cyc));
          check_output("write_addr", 32'(bus.waddr), 32'(mon_e.addr));
          check_output("write_data", bus.wdata, mon_e.data);
        end
      end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
        checks++;
        $display("[TB] FAIL missing_write: got none, expected r%0d=0x%0h at cycle %0d",
                 expq[0].addr, expq[0].data, expq[0].cyc);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    cyc    = 0;
    checks = 0;
    passes = 0;
    rst    = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;

    @(negedge clk);
    check_output("reset_wena", 32'(bus.wena), 32'd0);
    check_output("reset_waddr", 32'(bus.waddr), 32'd0);
    check_output("reset_wdata", bus.wdata, 32'd0);
    check_output("reset_count", 32'(bus.fifo_count), 32'd0);
    check_output("reset_mem_ready", 32'(bus.mem_ready), 32'd1);
    check_output("reset_stall", 32'(bus.stall_req), 32'd0);
    rst = 1'b0;

    // ALU only
    apply_stimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
    expect_write(cyc + 1, 5'd3, 32'h11);
    idle();
    idle();
    check_output("alu_only_then_idle", 32'(bus.wena), 32'd0);
    check_output("idle_holds_waddr", 32'(bus.waddr), 32'd3);

    // Contention: ALU wins, load drains next cycle
    apply_stimulus(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
    expect_write(cyc + 1, 5'd5, 32'hAA);
    expect_write(cyc + 2, 5'd6, 32'hBB);
    idle();
    check_output("contention_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    check_output("contention_count0", 32'(bus.fifo_count), 32'd0);

    // Same-cycle load to ALU destination is younger and survives
    apply_stimulus(1'b1, 5'd9, 32'h9, 1'b1, 5'd9, 32'h99);
    expect_write(cyc + 1, 5'd9, 32'h9);
    expect_write(cyc + 2, 5'd9, 32'h99);
    idle();
    idle();

    // Kill: older load superseded by ALU write
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1);
    apply_stimulus(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0);
    expect_write(cyc + 1, 5'd7, 32'h2);
    idle();
    check_output("kill_count1", 32'(bus.fifo_count), 32'd1);
    idle();
    check_output("kill_pop_wena", 32'(bus.wena), 32'd0);
    check_output("kill_count0", 32'(bus.fifo_count), 32'd0);

    // Zero register from both sources
    apply_stimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    check_output("zero_mem_ready", 32'(bus.mem_ready), 32'd1);
    idle();
    check_output("zero_wena", 32'(bus.wena), 32'd0);
    check_output("zero_count", 32'(bus.fifo_count), 32'd0);

    // Fill while ALU busy, then drain in push order (pointers wrap here)
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(10 + i), 32'h200 + i);
      expect_write(cyc + 1, 5'd1, 32'h100 + i);
    end
    t = cyc;
    for (int i = 0; i < 4; i++) expect_write(t + 2 + i, 5'(10 + i), 32'h200 + i);
    idle();
    check_output("full_count", 32'(bus.fifo_count), 32'd4);
    check_output("full_mem_ready", 32'(bus.mem_ready), 32'd0);
    check_output("full_stall", 32'(bus.stall_req), 32'd1);
    for (int i = 0; i < 4; i++) idle();
    check_output("drained_count", 32'(bus.fifo_count), 32'd0);
    check_output("drained_mem_ready", 32'(bus.mem_ready), 32'd1);
    check_output("drained_stall", 32'(bus.stall_req), 32'd0);

    // Reset mid-run with three buffered loads
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'd2, 32'h300 + i, 1'b1, 5'(12 + i), 32'h400 + i);
      expect_write(cyc + 1, 5'd2, 32'h300 + i);
    end
    idle();
    check_output("pre_reset_count", 32'(bus.fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_output("midreset_wena", 32'(bus.wena), 32'd0);
    check_output("midreset_waddr", 32'(bus.waddr), 32'd0);
    check_output("midreset_wdata", bus.wdata, 32'd0);
    check_output("midreset_count", 32'(bus.fifo_count), 32'd0);
    check_output("midreset_mem_ready", 32'(bus.mem_ready), 32'd1);
    check_output("midreset_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    check_output("post_reset_count", 32'(bus.fifo_count), 32'd0);

    // First write after release has normal latency
    apply_stimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    expect_write(cyc + 1, 5'd4, 32'h44);
    for (int i = 0; i < 3; i++) idle();

    check_output("queue_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of all write-data paths.
REQ-002 Parameter ADDR_WIDTH, default 5: register-address width.
REQ-003 Parameter FIFO_DEPTH, default 4: load-result buffer entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-007 alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-008 alu_data  input  DATA_WIDTH  ALU result.
REQ-009 mem_valid  input  1  load result offered.
REQ-010 mem_ready  output  1  load result accepted when mem_valid & mem_ready.
REQ-011 mem_addr  input  ADDR_WIDTH  load destination register.
REQ-012 mem_data  input  DATA_WIDTH  load result.
REQ-013 wena  output  1  register-file write enable, registered.
REQ-014 waddr  output  ADDR_WIDTH  register-file write address, registered.
REQ-015 wdata  output  DATA_WIDTH  register-file write data, registered.
REQ-016 fifo_count  output  clog2(FIFO_DEPTH)+1  occupied entries, including killed entries.
REQ-017 stall_req  output  1  asserted combinationally when fifo_count == FIFO_DEPTH.

Function
REQ-018 ALU write: alu_valid=1 with alu_addr!=0 SHALL produce wena=1, waddr=alu_addr, wdata=alu_data on the following cycle (latency 1).
REQ-019 Writes to address 0 from either source SHALL be discarded: never written, and mem pushes to address 0 never stored.
REQ-020 mem_ready SHALL equal !(fifo_count == FIFO_DEPTH).
REQ-021 Push: mem_valid & mem_ready & mem_addr!=0 SHALL store {addr, data, valid=1} at the tail.
REQ-022 Handshake: mem_valid & mem_ready & mem_addr==0 SHALL be accepted (ready honoured) but not stored.
REQ-023 Drain: in a cycle with no ALU write (per REQ-018) and a non-empty FIFO, the head SHALL pop.
REQ-024 Drain write: a popped head with valid=1 SHALL produce wena=1, waddr/wdata = head contents the next cycle.
REQ-025 Killed head: a popped head with valid=0 SHALL produce no write (wena=0 next cycle).
REQ-026 Priority: an ALU write SHALL always win the write port; the FIFO head waits, unchanged.
REQ-027 Kill rule: an ALU write to address A SHALL clear valid on every stored entry with addr A (younger ALU result supersedes older load).
REQ-028 Kill exemption: a mem push in the same cycle as the ALU write is younger and SHALL NOT be killed, even if mem_addr==A.
REQ-029 Push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-030 A push into a full FIFO cannot occur (mem_ready=0).
REQ-031 Pop on empty SHALL NOT occur.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 Ordering: drained entries SHALL be written in push order.
REQ-034 Idle output: when neither an ALU write nor a pop occurs, the next cycle SHALL have wena=0; waddr and wdata hold their previous values.

Reset
REQ-035 While rst=1, asynchronously: wena=0, waddr=0, wdata=0, head/tail pointers=0, fifo_count=0, all entry valid bits=0.
REQ-036 While rst=1, mem_ready SHALL be 1 and stall_req SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard all buffered entries with no write issued.
REQ-038 The first write after reset release SHALL follow REQ-018/REQ-023 with no extra latency.

Verification
REQ-039 ALU only: alu_valid=1, addr=3, data=0x11 at cycle N -> wena=1, waddr=3, wdata=0x11 at N+1; wena=0 at N+2.
REQ-040 Contention: same cycle alu (addr 5, 0xAA) and mem push (addr 6, 0xBB) -> N+1 writes r5=0xAA; N+2 writes r6=0xBB; fifo_count 1 then 0.
REQ-041 Fill: alu_valid held 1 (addr 1), 4 mem pushes -> fifo_count=4, mem_ready=0, stall_req=1; drop alu_valid -> 4 writes in push order, then mem_ready=1.
REQ-042 Kill: push mem (addr 7, 0x1), then ALU write addr 7 = 0x2 -> r7 written 0x2 only; popped killed entry gives a wena=0 cycle.
REQ-043 Zero register: alu addr 0 and mem addr 0 (handshake completes) -> no wena, fifo_count stays 0.
REQ-044 Reset mid-run: rst pulsed with fifo_count=3 -> outputs 0 immediately; no stale writes after release.
